// File: rtl/wordcount_pkg.sv
// Shared types and widths for the wordcount host/local data movers.
package wordcount_pkg;
  localparam int WORD_W         = 64;
  localparam int BEAT_W         = 512;
  localparam int WORDS_PER_BEAT = 8;

  typedef enum logic [2:0] {IDLE, REQ, STREAM, NEXT, DONE1} load_state_t;

  // Word count rounded up to a whole number of beats.
  function automatic logic [31:0] pad_words(input logic [31:0] n);
    return (n + 32'd7) & ~32'd7;
  endfunction
endpackage

// File: rtl/axis_beat_unpacker.sv
// Holds one 512-bit beat and emits its 64-bit lanes, lane 0 first, one per cycle.
module axis_beat_unpacker
  import wordcount_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [BEAT_W-1:0] i_data,
  input  logic [3:0]        i_keep_words,
  output logic              o_ready,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic              o_empty
);
  logic [BEAT_W-1:0] r_hold;
  logic [2:0]        r_lane;
  logic [3:0]        r_keep;
  logic              r_full;
  logic              w_accept;

  // A new beat may land in the same cycle lane 7 of the previous one is emitted.
  assign o_ready  = !r_full || (r_lane == 3'd7);
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_lane <= '0;
      r_keep <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_hold <= i_data;
      r_keep <= i_keep_words;
      r_lane <= '0;
      r_full <= 1'b1;
    end else if (r_full) begin
      r_lane <= r_lane + 3'd1;
      if (r_lane == 3'd7) r_full <= 1'b0;
    end
  end

  assign o_word       = r_hold[{r_lane, 6'b0} +: WORD_W];
  assign o_word_valid = r_full && ({1'b0, r_lane} < r_keep);
  assign o_empty      = !r_full;
endmodule

// File: rtl/simple_data_load.sv
// Host-to-local loader: issues chunked read requests, unpacks s_axis beats and
// writes the words to local memory starting at the latched offset.
//
// state  | meaning
// IDLE   | waiting for kick, busy low
// REQ    | launch read request for the current chunk
// STREAM | accept beats for the chunk, wait for ctrl_done
// NEXT   | retire chunk, decide whether more remain
// DONE1  | final cycle before returning to IDLE
module simple_data_load
  import wordcount_pkg::*;
#(
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       offset,
  input  logic [31:0]       words,
  input  logic [63:0]       memory_addr,
  output logic [31:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_we,
  output logic              ctrl_start,
  input  logic              ctrl_done,
  output logic [63:0]       ctrl_addr_offset,
  output logic [63:0]       ctrl_xfer_size_in_bytes,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [BEAT_W-1:0] s_axis_tdata
);
  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  load_state_t r_state, w_state_next;
  logic [31:0] r_offset, r_words, r_remaining, r_beats, r_widx, r_bidx;
  logic [63:0] r_haddr, r_ctrl_addr, r_ctrl_size;
  logic        r_done, r_busy, r_ctrl_start;
  logic [31:0] w_chunk, w_chunk_beats, w_left;
  logic [3:0]  w_keep;
  logic        w_permit, w_ready, w_empty, w_word_valid, w_accept;
  logic [WORD_W-1:0] w_word;

  assign w_chunk       = (r_remaining > MAX_W) ? MAX_W : r_remaining;
  assign w_chunk_beats = w_chunk >> 3;
  // Only the final beat of the load can carry padding lanes.
  assign w_left        = r_words - r_bidx;
  assign w_keep        = (w_left >= 32'd8) ? 4'd8 : w_left[3:0];
  assign w_permit      = (r_state == STREAM) && (r_beats < w_chunk_beats);
  assign s_axis_tready = w_permit && w_ready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  axis_beat_unpacker u_unpack (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (s_axis_tvalid && w_permit),
    .i_data       (s_axis_tdata),
    .i_keep_words (w_keep),
    .o_ready      (w_ready),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_empty      (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (kick) w_state_next = (words == 32'd0) ? DONE1 : REQ;
      REQ:     w_state_next = STREAM;
      STREAM:  if ((r_beats == w_chunk_beats) && w_empty && (r_done || ctrl_done))
                 w_state_next = NEXT;
      NEXT:    w_state_next = (r_remaining == w_chunk) ? DONE1 : REQ;
      DONE1:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_offset     <= '0;
      r_words      <= '0;
      r_remaining  <= '0;
      r_beats      <= '0;
      r_widx       <= '0;
      r_bidx       <= '0;
      r_haddr      <= '0;
      r_ctrl_addr  <= '0;
      r_ctrl_size  <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b1;
      r_ctrl_start <= 1'b0;
    end else begin
      r_busy       <= (w_state_next != IDLE);
      r_ctrl_start <= (r_state == REQ);
      case (r_state)
        IDLE: if (kick) begin
          r_offset    <= offset;
          r_words     <= words;
          r_remaining <= pad_words(words);
          r_haddr     <= memory_addr;
          r_widx      <= '0;
          r_bidx      <= '0;
        end
        REQ: begin
          r_ctrl_addr <= r_haddr;
          r_ctrl_size <= {32'd0, w_chunk} << 3;
          r_beats     <= '0;
          r_done      <= 1'b0;
        end
        STREAM: begin
          if (ctrl_done) r_done <= 1'b1;
          if (w_accept) begin
            r_beats <= r_beats + 32'd1;
            r_bidx  <= r_bidx + 32'd8;
          end
        end
        NEXT: begin
          r_remaining <= r_remaining - w_chunk;
          r_haddr     <= r_haddr + ({32'd0, w_chunk} << 3);
        end
        default: ;
      endcase
      if (!w_empty) r_widx <= r_widx + 32'd1;
    end
  end

  assign busy                    = r_busy;
  assign ctrl_start              = r_ctrl_start;
  assign ctrl_addr_offset        = r_ctrl_addr;
  assign ctrl_xfer_size_in_bytes = r_ctrl_size;
  assign mem_we                  = w_word_valid;
  assign mem_wdata               = w_word;
  assign mem_addr                = r_offset + r_widx;
endmodule

// File: tb/tb_simple_data_load.sv
// Scoreboard bench for simple_data_load: host model streams beats, monitor checks writes/requests.
module tb_simple_data_load;
  import wordcount_pkg::*;

  logic              clk = 1'b0;
  logic              reset, kick, busy;
  logic [31:0]       offset, words, mem_addr;
  logic [63:0]       memory_addr, mem_wdata, ctrl_addr_offset, ctrl_xfer_size_in_bytes;
  logic              mem_we, ctrl_start, ctrl_done, s_axis_tvalid, s_axis_tready;
  logic [BEAT_W-1:0] s_axis_tdata;

  always #5 clk = ~clk;

  simple_data_load #(.MAX_WORDS(512)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .kick                    (kick),
    .busy                    (busy),
    .offset                  (offset),
    .words                   (words),
    .memory_addr             (memory_addr),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_we                  (mem_we),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata)
  );

  typedef struct { logic [31:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic [63:0] addr; logic [63:0] size; } req_t;

  wr_t  exp_wr[$];
  req_t exp_req[$];
  req_t host_q[$];
  int   n_pass = 0, n_checks = 0;
  int   beat_cnt = 0, wr_seen = 0;
  bit   g_gaps = 0, g_early = 0, abort_host = 0, host_busy = 0;

  function automatic logic [63:0] host_word(input logic [63:0] a);
    return ({a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF) ^ {a[63:32], 32'h0};
  endfunction

  function automatic logic [BEAT_W-1:0] make_beat(input logic [63:0] a);
    logic [BEAT_W-1:0] v;
    for (int i = 0; i < WORDS_PER_BEAT; i++) v[i*64 +: 64] = host_word(a + 64'(i * 8));
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: actual=0x%0h required=none", name, act);
  endtask

  // Monitor: every write and every request is popped against the scoreboard.
  initial begin : monitor
    wr_t w;
    req_t r;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        wr_seen++;
        if (exp_wr.size() == 0) fail_now("unexpected_write", 64'(mem_addr));
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.addr));
          check("wr_data", mem_wdata, w.data);
        end
      end
      if (ctrl_start === 1'b1) begin
        host_q.push_back('{ctrl_addr_offset, ctrl_xfer_size_in_bytes});
        if (exp_req.size() == 0) fail_now("unexpected_request", ctrl_addr_offset);
        else begin
          r = exp_req.pop_front();
          check("req_addr", ctrl_addr_offset, r.addr);
          check("req_size", ctrl_xfer_size_in_bytes, r.size);
        end
      end
    end
  end

  task automatic pulse_done();
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
  endtask

  // Host read master: serves each request as size/64 beats with optional gaps.
  initial begin : host
    req_t r;
    int nb, waited;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    ctrl_done     = 1'b0;
    forever begin
      @(negedge clk);
      if (host_q.size() > 0 && !abort_host) begin
        r = host_q.pop_front();
        host_busy = 1;
        nb = (r.size[63:12] != 0) ? 64 : int'(r.size[11:0] >> 6);
        for (int b = 0; b < nb && !abort_host; b++) begin
          if (g_early && b == nb - 1) pulse_done();
          if (g_gaps) repeat ($urandom_range(0, 4)) @(negedge clk);
          s_axis_tdata  = make_beat(r.addr + 64'(b * 64));
          s_axis_tvalid = 1'b1;
          waited = 0;
          while (s_axis_tready !== 1'b1 && waited < 300 && !abort_host) begin
            @(negedge clk);
            waited++;
          end
          if (abort_host) begin s_axis_tvalid = 1'b0; break; end
          if (waited >= 300) begin
            fail_now("beat_handshake_timeout", 64'(waited));
            s_axis_tvalid = 1'b0;
            break;
          end
          @(posedge clk); #1;
          s_axis_tvalid = 1'b0;
          beat_cnt++;
          @(negedge clk);
          if (!abort_host) check("accept_to_we", 64'(mem_we), 64'd1);
        end
        if (!g_early && !abort_host) pulse_done();
        host_busy = 0;
      end
    end
  end

  // Reference: expected writes per word and requests cut from the padded byte total.
  task automatic start_load(input string tag, input logic [31:0] off, input logic [31:0] nw,
                            input logic [63:0] ma, input bit gaps, input bit early, input bit rekick);
    logic [63:0] total, piece, ha;
    g_gaps = gaps; g_early = early; beat_cnt = 0;
    for (int i = 0; i < int'(nw); i++)
      exp_wr.push_back('{off + 32'(i), host_word(ma + 64'(i) * 64'd8)});
    total = 64'((nw + 32'd7) & ~32'd7) * 64'd8;
    ha = ma;
    while (total != 0) begin
      piece = (total > 64'd4096) ? 64'd4096 : total;
      exp_req.push_back('{ha, piece});
      ha += piece;
      total -= piece;
    end
    @(posedge clk); #1;
    offset = off; words = nw; memory_addr = ma; kick = 1'b1;
    @(posedge clk); #1;
    kick = 1'b0; offset = $urandom; words = $urandom; memory_addr = {32'($urandom), 32'($urandom)};
    check({tag, "_busy_after_kick"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({tag, "_kick_to_start"}, 64'(ctrl_start), 64'(nw != 0));
    if (rekick) begin
      repeat (3) @(posedge clk); #1;
      kick = 1'b1; words = 32'd5;
      @(posedge clk); #1;
      kick = 1'b0;
    end
  endtask

  task automatic finish_load(input string tag, input logic [31:0] nw);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 20000) begin @(negedge clk); cyc++; end
    if (cyc >= 20000) fail_now({tag, "_busy_timeout"}, 64'(cyc));
    repeat (2) @(negedge clk);
    check({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_reqs_left"}, 64'(exp_req.size()), 64'd0);
    check({tag, "_beats"}, 64'(beat_cnt), 64'((nw + 32'd7) >> 3));
    exp_wr.delete();
    exp_req.delete();
  endtask

  task automatic run_load(input string tag, input logic [31:0] off, input logic [31:0] nw,
                          input logic [63:0] ma, input bit gaps, input bit early, input bit rekick);
    start_load(tag, off, nw, ma, gaps, early, rekick);
    finish_load(tag, nw);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int cyc, base;
    logic [31:0] nw;
    reset = 1'b1; kick = 1'b0; offset = '0; words = '0; memory_addr = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ctrl_start", 64'(ctrl_start), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_ctrl_addr", ctrl_addr_offset, 64'd0);
    check("rst_ctrl_size", ctrl_xfer_size_in_bytes, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("busy_after_reset", 64'(busy), 64'd0);

    run_load("w16",   32'h100, 32'd16,   64'h1000, 0, 0, 1);
    run_load("w13",   32'h200, 32'd13,   64'h2000, 0, 0, 0);
    run_load("w1200", 32'h0,   32'd1200, 64'h10_0000, 0, 0, 0);
    run_load("w1200g",32'h0,   32'd1200, 64'h10_0000, 1, 1, 0);
    run_load("w0",    32'h300, 32'd0,    64'h3000, 0, 0, 0);
    run_load("wrap",  32'hFFFF_FFF8, 32'd20, 64'h4000, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      nw = 32'($urandom_range(1, 700));
      run_load("rand", 32'($urandom), nw, {32'($urandom), 32'($urandom) & 32'hFFFF_FFF8},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of streaming a 64-word load.
    base = wr_seen;
    start_load("rst64", 32'h500, 32'd64, 64'h8000, 0, 0, 0);
    cyc = 0;
    while (wr_seen < base + 20 && cyc < 2000) begin @(negedge clk); cyc++; end
    if (cyc >= 2000) fail_now("rst64_write_timeout", 64'(wr_seen - base));
    @(posedge clk); #1;
    reset = 1'b1; abort_host = 1;
    @(posedge clk); #1;
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_tready", 64'(s_axis_tready), 64'd0);
    check("abort_ctrl_start", 64'(ctrl_start), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_wr.delete(); exp_req.delete(); host_q.delete();
    @(posedge clk); #1;
    check("busy_after_abort", 64'(busy), 64'd0);
    cyc = 0;
    while (host_busy && cyc < 100) begin @(negedge clk); cyc++; end
    if (cyc >= 100) fail_now("host_abort_timeout", 64'(cyc));
    abort_host = 0;
    run_load("post_rst", 32'h600, 32'd64, 64'h9000, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
